psg_audio_mixer: RTL and testbench



---
 rtl/psg_audio_pkg.sv | 47 ++++
 rtl/psg_dc_blocker.sv | 46 ++++
 rtl/psg_audio_mixer.sv | 124 ++++++++++++
 tb/tb_psg_audio_mixer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_audio_pkg.sv
// rtl/psg_audio_pkg.sv - shared types, widths and the channel mix function for the PSG audio mixer
package psg_audio_pkg;

    localparam int MIX_W    = 10;
    localparam int SAMPLE_W = 16;
    localparam int X_SHIFT  = 5;
    localparam int X_W      = MIX_W + X_SHIFT;

    typedef enum logic [1:0] {
        MONO  = 2'd0,
        ABC   = 2'd1,
        ACB   = 2'd2,
        MONO2 = 2'd3
    } stereo_mode_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Returns {left, right}; the centre channel goes to both sides at unit weight.
    function automatic logic [2*MIX_W-1:0] mix_channels(input stereo_mode_t mode,
                                                        input logic [7:0] a,
                                                        input logic [7:0] b,
                                                        input logic [7:0] c);
        logic [MIX_W-1:0] a10, b10, c10, l, r;
        a10 = MIX_W'(a);
        b10 = MIX_W'(b);
        c10 = MIX_W'(c);
        case (mode)
            ABC: begin
                l = (a10 << 1) + b10;
                r = (c10 << 1) + b10;
            end
            ACB: begin
                l = (a10 << 1) + c10;
                r = (b10 << 1) + c10;
            end
            default: begin
                l = a10 + b10 + c10;
                r = l;
            end
        endcase
        return {l, r};
    endfunction

endpackage

// File: rtl/psg_dc_blocker.sv
// rtl/psg_dc_blocker.sv - one-pole DC blocker for one stereo side, with mute and saturation
module psg_dc_blocker
    import psg_audio_pkg::*;
#(
    parameter int HP_SHIFT = 10
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       in_valid,
    input  logic [X_W-1:0]             x,
    input  logic                       dc_en,
    input  logic                       mute,
    output logic signed [SAMPLE_W-1:0] y
);
    localparam int ACC_W = X_W + HP_SHIFT;
    localparam int DW    = SAMPLE_W + 1;
    localparam logic signed [DW-1:0] SAT_HI = DW'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [DW-1:0] SAT_LO = ~SAT_HI;

    logic [ACC_W-1:0]     dcacc;
    logic [X_W-1:0]       dc;
    logic signed [DW-1:0] diff;

    assign dc = dcacc[ACC_W-1:HP_SHIFT];

    always_comb begin
        diff = dc_en ? ($signed(DW'(x)) - $signed(DW'(dc))) : $signed(DW'(x));
        if (mute)
            y = '0;
        else if (diff > SAT_HI)
            y = SAT_HI[SAMPLE_W-1:0];
        else if (diff < SAT_LO)
            y = SAT_LO[SAMPLE_W-1:0];
        else
            y = diff[SAMPLE_W-1:0];
    end

    // The estimator tracks the input even while bypassed or muted so re-enabling is click-free.
    always_ff @(posedge CLK) begin
        if (RESET)
            dcacc <= '0;
        else if (in_valid)
            dcacc <= dcacc + ACC_W'(x) - ACC_W'(dc);
    end

endmodule

// File: rtl/psg_audio_mixer.sv
// rtl/psg_audio_mixer.sv - PSG channel stereo mixer, CE-driven box decimator and output holding register
module psg_audio_mixer
    import psg_audio_pkg::*;
#(
    parameter int DECIM_LOG2 = 4,
    parameter int HP_SHIFT   = 10
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CE,
    input  logic [7:0]                 CH_A,
    input  logic [7:0]                 CH_B,
    input  logic [7:0]                 CH_C,
    input  logic [1:0]                 STEREO_MODE,
    input  logic                       DC_EN,
    input  logic                       MUTE,
    output logic signed [SAMPLE_W-1:0] OUT_L,
    output logic signed [SAMPLE_W-1:0] OUT_R,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic                       OVERRUN
);
    localparam int ACC_W = MIX_W + DECIM_LOG2;

    logic [MIX_W-1:0]            mix_l, mix_r;
    logic [ACC_W-1:0]            acc_l, acc_r, sum_l, sum_r;
    logic [DECIM_LOG2-1:0]       win_cnt;
    logic                        s0_valid, s1_valid;
    logic [X_W-1:0]              x_l, x_r;
    logic signed [SAMPLE_W-1:0]  y_l, y_r;
    out_state_t                  state, state_nxt;
    logic                        load, drop;

    assign {mix_l, mix_r} = mix_channels(stereo_mode_t'(STEREO_MODE), CH_A, CH_B, CH_C);

    // s0: window sum captured on the closing CE; s1: scaled sample feeding the DC blockers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_l    <= '0;
            acc_r    <= '0;
            sum_l    <= '0;
            sum_r    <= '0;
            win_cnt  <= '0;
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            x_l      <= '0;
            x_r      <= '0;
        end else begin
            s0_valid <= 1'b0;
            s1_valid <= s0_valid;
            if (s0_valid) begin
                x_l <= {sum_l[ACC_W-1:DECIM_LOG2], {X_SHIFT{1'b0}}};
                x_r <= {sum_r[ACC_W-1:DECIM_LOG2], {X_SHIFT{1'b0}}};
            end
            if (CE) begin
                if (win_cnt == {DECIM_LOG2{1'b1}}) begin
                    sum_l    <= acc_l + ACC_W'(mix_l);
                    sum_r    <= acc_r + ACC_W'(mix_r);
                    acc_l    <= '0;
                    acc_r    <= '0;
                    win_cnt  <= '0;
                    s0_valid <= 1'b1;
                end else begin
                    acc_l   <= acc_l + ACC_W'(mix_l);
                    acc_r   <= acc_r + ACC_W'(mix_r);
                    win_cnt <= win_cnt + DECIM_LOG2'(1);
                end
            end
        end
    end

    psg_dc_blocker #(.HP_SHIFT(HP_SHIFT)) u_dc_l (
        .CLK(CLK), .RESET(RESET), .in_valid(s1_valid), .x(x_l),
        .dc_en(DC_EN), .mute(MUTE), .y(y_l)
    );

    psg_dc_blocker #(.HP_SHIFT(HP_SHIFT)) u_dc_r (
        .CLK(CLK), .RESET(RESET), .in_valid(s1_valid), .x(x_r),
        .dc_en(DC_EN), .mute(MUTE), .y(y_r)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (s1_valid) begin
                    state_nxt = FULL;
                    load      = 1'b1;
                end
            end
            FULL: begin
                if (OUT_READY) begin
                    load      = s1_valid;
                    state_nxt = s1_valid ? FULL : EMPTY;
                end else if (s1_valid) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= EMPTY;
            OUT_L   <= '0;
            OUT_R   <= '0;
            OVERRUN <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                OUT_L <= y_l;
                OUT_R <= y_r;
            end
            if (drop)
                OVERRUN <= 1'b1;
        end
    end

    assign OUT_VALID = (state == FULL);

endmodule

// File: tb/tb_psg_audio_mixer.sv
// tb/tb_psg_audio_mixer.sv - directed self-checking bench for psg_audio_mixer
module tb_psg_audio_mixer;

    logic              CLK = 1'b0;
    logic              RESET, CE, DC_EN, MUTE, OUT_READY;
    logic [7:0]        CH_A, CH_B, CH_C;
    logic [1:0]        STEREO_MODE;
    logic signed [15:0] OUT_L, OUT_R;
    logic              OUT_VALID, OVERRUN;

    int n_cmp = 0;
    int n_err = 0;

    psg_audio_mixer #(.DECIM_LOG2(4), .HP_SHIFT(10)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .CH_A(CH_A), .CH_B(CH_B), .CH_C(CH_C),
        .STEREO_MODE(STEREO_MODE), .DC_EN(DC_EN), .MUTE(MUTE),
        .OUT_L(OUT_L), .OUT_R(OUT_R), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; CE = 1'b0; OUT_READY = 1'b1; DC_EN = 1'b0; MUTE = 1'b0;
        STEREO_MODE = 2'd0; CH_A = 8'h00; CH_B = 8'h00; CH_C = 8'h00;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Drives one full 16-CE window and waits a bounded time for the resulting sample.
    task automatic run_window(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic mute,
                              output logic signed [15:0] l, output logic signed [15:0] r,
                              output bit seen);
        STEREO_MODE = mode; CH_A = a; CH_B = b; CH_C = c; MUTE = mute; CE = 1'b1;
        repeat (16) tick();
        CE = 1'b0;
        seen = 1'b0;
        l = '0;
        r = '0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (OUT_VALID) begin
                seen = 1'b1;
                l = OUT_L;
                r = OUT_R;
            end
        end
        MUTE = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; CE = 1'b1; OUT_READY = 1'b0; DC_EN = 1'b0; MUTE = 1'b0;
        STEREO_MODE = 2'd0; CH_A = 8'hFF; CH_B = 8'hFF; CH_C = 8'hFF;
        repeat (3) tick();
        n_cmp++; if (OUT_L !== 16'sd0)  begin n_err++; $display("FAIL reset_out_l got %0d want 0", OUT_L); end
        n_cmp++; if (OUT_R !== 16'sd0)  begin n_err++; $display("FAIL reset_out_r got %0d want 0", OUT_R); end
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", OUT_VALID); end
        n_cmp++; if (OVERRUN !== 1'b0)  begin n_err++; $display("FAIL reset_overrun got %b want 0", OVERRUN); end
        CE = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic test_full_scale();
        logic exp_v;
        do_reset();
        CH_A = 8'hFF; CH_B = 8'hFF; CH_C = 8'hFF; OUT_READY = 1'b1; CE = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            tick();
            exp_v = (k >= 18) && ((k - 18) % 16 == 0);
            n_cmp++;
            if (OUT_VALID !== exp_v) begin
                n_err++; $display("FAIL full_scale_valid cycle %0d got %b want %b", k, OUT_VALID, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (OUT_L !== 16'sd24480 || OUT_R !== 16'sd24480) begin
                    n_err++; $display("FAIL full_scale_value cycle %0d got %0d/%0d want 24480/24480", k, OUT_L, OUT_R);
                end
            end
        end
        CE = 1'b0;
    endtask

    task automatic test_stereo();
        logic [1:0]  v_mode [7] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2};
        logic [7:0]  v_a    [7] = '{8'h10, 8'h10, 8'h01, 8'h01, 8'h80, 8'hFF, 8'h00};
        logic [7:0]  v_b    [7] = '{8'h08, 8'h08, 8'h02, 8'h02, 8'h40, 8'hFF, 8'hFF};
        logic [7:0]  v_c    [7] = '{8'h00, 8'h00, 8'h03, 8'h03, 8'h20, 8'hFF, 8'h01};
        logic        v_mute [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int          v_l    [7] = '{1280, 1024, 192, 192, 10240, 0, 32};
        int          v_r    [7] = '{256, 512, 192, 192, 4096, 0, 16352};
        logic signed [15:0] l, r;
        bit seen;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            run_window(v_mode[i], v_a[i], v_b[i], v_c[i], v_mute[i], l, r, seen);
            n_cmp++;
            if (!seen || l !== 16'(v_l[i]) || r !== 16'(v_r[i])) begin
                n_err++; $display("FAIL stereo_vec %0d seen=%b got %0d/%0d want %0d/%0d", i, seen, l, r, v_l[i], v_r[i]);
            end
        end
        // Mode switch halfway through a window: first 8 CEs ABC, last 8 ACB.
        CH_A = 8'h10; CH_B = 8'h08; CH_C = 8'h00; STEREO_MODE = 2'd1; CE = 1'b1;
        repeat (8) tick();
        STEREO_MODE = 2'd2;
        repeat (8) tick();
        CE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (OUT_VALID) begin seen = 1'b1; l = OUT_L; r = OUT_R; end
        end
        n_cmp++;
        if (!seen || l !== 16'sd1152 || r !== 16'sd384) begin
            n_err++; $display("FAIL stereo_mode_switch seen=%b got %0d/%0d want 1152/384", seen, l, r);
        end
    endtask

    task automatic test_dc_block();
        logic signed [15:0] cur, prev;
        bit seen, alive;
        do_reset();
        DC_EN = 1'b1; CH_A = 8'hFF; CH_B = 8'hFF; CH_C = 8'hFF; OUT_READY = 1'b1; CE = 1'b1;
        prev = 16'sd32767;
        cur = '0;
        alive = 1'b1;
        for (int s = 0; s <= 1024 && alive; s++) begin
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                if (OUT_VALID) begin seen = 1'b1; cur = OUT_L; end
            end
            n_cmp++;
            if (!seen) begin
                n_err++; alive = 1'b0;
                $display("FAIL dc_timeout sample %0d got no OUT_VALID want OUT_VALID", s);
            end else begin
                n_cmp++;
                if (cur > prev) begin
                    n_err++; $display("FAIL dc_monotonic sample %0d got %0d want <= %0d", s, cur, prev);
                end
                if (s == 0) begin
                    n_cmp++;
                    if (cur !== 16'sd24480) begin n_err++; $display("FAIL dc_first got %0d want 24480", cur); end
                end
                if (s == 1) begin
                    n_cmp++;
                    if (cur !== 16'sd24457) begin n_err++; $display("FAIL dc_second got %0d want 24457", cur); end
                end
                if (s == 1024) begin
                    n_cmp++;
                    if (cur < 16'sd8990 || cur > 16'sd9015 || OUT_R !== cur) begin
                        n_err++; $display("FAIL dc_idx1024 got %0d/%0d want 8990..9015 on both", cur, OUT_R);
                    end
                end
                prev = cur;
            end
        end
        CE = 1'b0;
        DC_EN = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        OUT_READY = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            CH_A = (k <= 16) ? 8'hFF : 8'h00;
            CH_B = CH_A; CH_C = CH_A; CE = 1'b1;
            tick();
            if (k >= 18) begin
                n_cmp++;
                if (OUT_VALID !== 1'b1 || OUT_L !== 16'sd24480 || OUT_R !== 16'sd24480) begin
                    n_err++; $display("FAIL overrun_hold cycle %0d got v=%b %0d/%0d want v=1 24480/24480", k, OUT_VALID, OUT_L, OUT_R);
                end
            end
            n_cmp++;
            if (OVERRUN !== (k >= 34)) begin
                n_err++; $display("FAIL overrun_flag cycle %0d got %b want %b", k, OVERRUN, (k >= 34));
            end
        end
        CE = 1'b0;
        OUT_READY = 1'b1;
        tick();
        n_cmp++;
        if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL overrun_drain_valid got %b want 0", OUT_VALID); end
        n_cmp++;
        if (OVERRUN !== 1'b1) begin n_err++; $display("FAIL overrun_sticky got %b want 1", OVERRUN); end
    endtask

    task automatic test_reset_mid_window();
        logic exp_v;
        do_reset();
        CH_A = 8'hFF; CH_B = 8'hFF; CH_C = 8'hFF; OUT_READY = 1'b1; CE = 1'b1;
        repeat (8) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            CE = (k <= 16);
            tick();
            exp_v = (k == 18);
            n_cmp++;
            if (OUT_VALID !== exp_v) begin
                n_err++; $display("FAIL reset_mid_valid cycle %0d got %b want %b", k, OUT_VALID, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (OUT_L !== 16'sd24480 || OVERRUN !== 1'b0) begin
                    n_err++; $display("FAIL reset_mid_value got %0d ovr=%b want 24480 ovr=0", OUT_L, OVERRUN);
                end
            end
        end
        CE = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        OUT_READY = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            CH_A = (k <= 16) ? 8'hFF : 8'h10;
            CH_B = (k <= 16) ? 8'hFF : 8'h00;
            CH_C = CH_B;
            CE = (k <= 32);
            OUT_READY = (k == 34);
            tick();
            if (k == 33) begin
                n_cmp++;
                if (OUT_VALID !== 1'b1 || OUT_L !== 16'sd24480) begin
                    n_err++; $display("FAIL b2b_before got v=%b %0d want v=1 24480", OUT_VALID, OUT_L);
                end
            end
            if (k == 34 || k == 35) begin
                n_cmp++;
                if (OUT_VALID !== 1'b1 || OUT_L !== 16'sd512 || OUT_R !== 16'sd512 || OVERRUN !== 1'b0) begin
                    n_err++; $display("FAIL b2b_reload cycle %0d got v=%b %0d/%0d ovr=%b want v=1 512/512 ovr=0",
                                      k, OUT_VALID, OUT_L, OUT_R, OVERRUN);
                end
            end
        end
        OUT_READY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_stereo();
        test_overrun();
        test_reset_mid_window();
        test_back_to_back();
        test_dc_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
